song_selector: RTL

//  Parametrised song browser for autoPlay. Debounced prev/next/confirm buttons move a wrap-around cursor over NUM_SONGS.

---
 rtl/song_sel_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/song_selector.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/song_sel_pkg.sv
// rtl/song_sel_pkg.sv - glyph codes, song name table and FSM state codes for song_selector
package song_sel_pkg;

    // Digits per stored song name; shorter names are padded with blanks on the right.
    localparam int SONG_DIGITS     = 6;
    localparam int SONG_TABLE_SIZE = 4;

    // Glyph code space: '0'..'9' -> 0..9, 'A'..'Z' -> 11..36, 63 = blank.
    localparam logic [5:0] G_A     = 6'b001011;
    localparam logic [5:0] G_C     = 6'b001101;
    localparam logic [5:0] G_N     = 6'b011000;
    localparam logic [5:0] G_BLANK = 6'b111111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BROWSE = 2'd1;
    localparam state_t ST_PEND   = 2'd2;

    // Map one ASCII character of a name to its glyph code.
    function automatic logic [5:0] char_glyph(input logic [7:0] c);
        logic [5:0] g;
        g = G_BLANK;
        if (c >= 8'h30 && c <= 8'h39) begin
            g = 6'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            g = 6'(c - 8'h41 + 8'd11);
        end
        return g;
    endfunction

    // Glyph string of a song; digit 0 (bits [5:0]) is the leftmost character.
    function automatic logic [SONG_DIGITS*6-1:0] song_glyphs(input int unsigned idx);
        logic [8*SONG_DIGITS-1:0] name;
        logic [SONG_DIGITS*6-1:0] g;
        case (idx)
            0:       name = "CANNON";
            1:       name = "CALSEN";
            2:       name = "FLWRD ";
            3:       name = "ODEJOY";
            default: name = "ERROR ";
        endcase
        for (int d = 0; d < SONG_DIGITS; d++) begin
            g[d*6 +: 6] = char_glyph(name[8*(SONG_DIGITS-1-d) +: 8]);
        end
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, level debouncer and one-cycle press pulse for a raw button
module btn_debounce #(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive synchronised samples that differ from the accepted level;
    // the DEB_CYCLES-th such sample flips the level, any matching sample restarts the count.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, debounce and pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/song_selector.sv
// rtl/song_selector.sv - button-driven song browser with glyph display and confirm handshake; SONG_SEL_BLINK_EN adds display blinking
module song_selector
    import song_sel_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int IDX_W      = 8,
    parameter int NUM_DIGITS = 6,
    parameter int DEB_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    prev_btn,
    input  logic                    next_btn,
    input  logic                    confirm_btn,
    output logic [IDX_W-1:0]        sel_index,
    output logic                    sel_valid,
    input  logic                    sel_ready,
    output logic [IDX_W-1:0]        cursor,
    output logic [NUM_DIGITS*6-1:0] seg
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SONGS - 1);
    localparam logic [SONG_DIGITS*6-1:0] RST_GLYPHS = song_glyphs(0);

    logic                    prev_press, next_press, confirm_press;
    logic [2:0]              btn_level_unused;
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cursor_q, cursor_d;
    logic [IDX_W-1:0]        sel_index_q, sel_index_d;
    logic                    sel_valid_q, sel_valid_d;
    logic [NUM_DIGITS*6-1:0] seg_q, seg_d;
    logic [SONG_DIGITS*6-1:0] glyphs;
    logic [NUM_DIGITS*6-1:0] cur_seg, rst_seg;
    logic                    browsing;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
        .clk(clk), .rst_n(rst_n), .raw(prev_btn), .level(btn_level_unused[0]), .press(prev_press));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk(clk), .rst_n(rst_n), .raw(next_btn), .level(btn_level_unused[1]), .press(next_press));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_confirm (
        .clk(clk), .rst_n(rst_n), .raw(confirm_btn), .level(btn_level_unused[2]), .press(confirm_press));

    assign glyphs = song_glyphs(32'(cursor_q));

    // Fit the fixed-width name onto NUM_DIGITS digits, padding extra digits with blanks.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i < SONG_DIGITS) begin : g_name
            assign cur_seg[i*6 +: 6] = glyphs[i*6 +: 6];
            assign rst_seg[i*6 +: 6] = RST_GLYPHS[i*6 +: 6];
        end else begin : g_pad
            assign cur_seg[i*6 +: 6] = G_BLANK;
            assign rst_seg[i*6 +: 6] = G_BLANK;
        end
    end

    // Cursor stepping, confirm capture and request handshake.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        sel_index_d = sel_index_q;
        sel_valid_d = sel_valid_q;
        browsing    = enable && (state_q != ST_IDLE);
        if (browsing && next_press && !prev_press) begin
            cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
        end else if (browsing && prev_press && !next_press) begin
            cursor_d = (cursor_q == '0) ? LAST : cursor_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_BROWSE;
            end
            ST_BROWSE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (confirm_press) begin
                    sel_index_d = cursor_q;
                    sel_valid_d = 1'b1;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                // A pending request is only ever retired by the player, never withdrawn.
                if (sel_valid_q && sel_ready) begin
                    sel_valid_d = 1'b0;
                    state_d     = enable ? ST_BROWSE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SONG_SEL_BLINK_EN
    localparam int BLINK_W = 24;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    // Blink phase generator; restarts in the "on" phase whenever the cursor moves.
    always_comb begin
        if (cursor_d != cursor_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_on_d  = (&blink_cnt_q) ? ~blink_on_q : blink_on_q;
        end
    end

    // Blink counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Blank the display in the off phase while the browsed song is not the settled selection.
    always_comb begin
        seg_d = cur_seg;
        if (((cursor_q != sel_index_q) || (state_q == ST_PEND)) && !blink_on_q) begin
            seg_d = {NUM_DIGITS{G_BLANK}};
        end
    end
`else
    // Steady display of the browsed song.
    always_comb begin
        seg_d = cur_seg;
    end
`endif

    // Selector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            sel_index_q <= '0;
            sel_valid_q <= 1'b0;
            seg_q       <= rst_seg;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            sel_index_q <= sel_index_d;
            sel_valid_q <= sel_valid_d;
            seg_q       <= seg_d;
        end
    end

    assign cursor    = cursor_q;
    assign sel_index = sel_index_q;
    assign sel_valid = sel_valid_q;
    assign seg       = seg_q;

endmodule
